// File: rtl/fetch_exec_ctrl.sv
// Multi-cycle fetch/execute sequencer for the IR/RF/ARF datapath: two-byte fetch from PC,
// then one register-level operation per instruction.
module fetch_exec_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mem_ack_i,
    input  logic [15:0]      ir_q_i,
    output logic             mem_req_o,
    output logic             ir_enable_o,
    output logic             ir_lh_o,
    output logic [1:0]       ir_funsel_o,
    output logic [1:0]       rf_funsel_o,
    output logic [3:0]       rf_regsel_o,
    output logic [3:0]       rf_tsel_o,
    output logic [1:0]       arf_funsel_o,
    output logic [3:0]       arf_regsel_o,
    output logic [1:0]       arf_outbsel_o,
    output logic             bus_sel_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam logic [1:0] FsClr  = 2'b00;
    localparam logic [1:0] FsLoad = 2'b01;
    localparam logic [1:0] FsDec  = 2'b10;
    localparam logic [1:0] FsInc  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFetchL,
        StFetchH,
        StExec,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] op;
    logic [1:0] dst;
    logic [3:0] dst_sel;
    logic       ack;
    logic       unused_ir;

    assign op        = ir_q_i[15:13];
    assign dst       = ir_q_i[12:11];
    assign dst_sel   = 4'b1000 >> dst;
    assign unused_ir = ^ir_q_i[10:0];
    // Reset wins over a same-cycle ack so an abandoned fetch writes neither IR nor PC.
    assign ack       = mem_ack_i & ~reset_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StFetchL;
            StFetchL: if (ack) state_d = StFetchH;
            StFetchH: if (ack) state_d = StExec;
            StExec: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (op == 3'b111) ? StHalt : StFetchL;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_req_o     = 1'b0;
        ir_enable_o   = 1'b0;
        ir_lh_o       = 1'b0;
        ir_funsel_o   = FsClr;
        rf_funsel_o   = FsClr;
        rf_regsel_o   = 4'b0000;
        rf_tsel_o     = 4'b0000;
        arf_funsel_o  = FsClr;
        arf_regsel_o  = 4'b0000;
        arf_outbsel_o = 2'b00;
        bus_sel_o     = 1'b0;
        unique case (state_q)
            StFetchL, StFetchH: begin
                mem_req_o = 1'b1;
                ir_lh_o   = (state_q == StFetchH);
                if (ack) begin
                    ir_enable_o  = 1'b1;
                    ir_funsel_o  = FsLoad;
                    arf_regsel_o = 4'b1000;
                    arf_funsel_o = FsInc;
                end
            end
            StExec: begin
                unique case (op)
                    3'b001: begin
                        rf_regsel_o = dst_sel;
                        rf_funsel_o = FsLoad;
                        bus_sel_o   = 1'b1;
                    end
                    3'b010: begin
                        rf_regsel_o = dst_sel;
                        rf_funsel_o = FsInc;
                    end
                    3'b011: begin
                        rf_regsel_o = dst_sel;
                        rf_funsel_o = FsDec;
                    end
                    3'b100: begin
                        rf_regsel_o = dst_sel;
                        rf_funsel_o = FsClr;
                    end
                    3'b110: begin
                        arf_regsel_o = 4'b1000;
                        arf_funsel_o = FsLoad;
                        bus_sel_o    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_q == StFetchL) || (state_q == StFetchH) || (state_q == StExec);
    assign halted_o    = (state_q == StHalt);
    assign instr_cnt_o = cnt_q;

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
Multi-cycle controller that sequences the existing datapath blocks: part2a_IR, part2b_RF and part2c_ARF.
- Fetches a 16-bit instruction as two byte reads from memory at PC: low half first, then high half.
- Executes one register-level operation per instruction.
- Drives the shared datapath input bus select, the IR/RF/ARF enables and function selects, and a simple req/ack memory handshake.
- Sits between the top-level start/halt logic and the datapath.

Parameters:
CNT_W, 8, width of the retired-instruction counter

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high
start  in  1  leaves IDLE when high
mem_ack  in  1  memory data valid this cycle
ir_q  in  16  current IR contents
mem_req  out  1  memory read request; address is ARF OutB
ir_enable  out  1  IR enable
ir_lh  out  1  IR half select: 0 = bits 7:0, 1 = bits 15:8
ir_funsel  out  2  IR function select
rf_funsel  out  2  RF function select
rf_regsel  out  4  RF general-register enables
rf_tsel  out  4  RF temp-register enables, always 0000
arf_funsel  out  2  ARF function select
arf_regsel  out  4  ARF enables; bit 3 = PC
arf_outbsel  out  2  ARF OutB select; 00 = PC
bus_sel  out  1  datapath input bus: 0 = memory data, 1 = ir_q[7:0]
busy  out  1  high in FETCH_L, FETCH_H or EXEC
halted  out  1  high in HALT
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Function select encoding, shared by all blocks: 00 clear, 01 load, 10 decrement, 11 increment.
- State register: IDLE, FETCH_L, FETCH_H, EXEC, HALT.
- Reset:
  - Priority over start and mem_ack.
  - Next edge: state = IDLE, instr_cnt = 0.
  - Reset mid-fetch abandons the fetch; mem_req is low from the cycle after the reset edge.
- Outputs are combinational from state, mem_ack and ir_q.
- Default for every output unless stated below: enables and regsels 0, funsels 00, bus_sel 0, arf_outbsel 00, rf_tsel 0000.
- IDLE: start=1 -> FETCH_L; otherwise stay.
- FETCH_L:
  - mem_req=1, arf_outbsel=00.
  - In a cycle with mem_ack=1: ir_enable=1, ir_lh=0, ir_funsel=01; PC increments (arf_regsel=1000, arf_funsel=11); next state FETCH_H.
  - mem_ack=0: stay (unbounded wait states).
- FETCH_H: identical to FETCH_L except ir_lh=1; next state EXEC.
- EXEC: exactly one cycle. Decode op = ir_q[15:13], dst = ir_q[12:11].
  - dst to rf_regsel: 00->1000, 01->0100, 10->0010, 11->0001.
  - 000 NOP: no enables.
  - 001 LDI: rf_regsel=dst, rf_funsel=01, bus_sel=1.
  - 010 INC: rf_regsel=dst, rf_funsel=11.
  - 011 DEC: rf_regsel=dst, rf_funsel=10.
  - 100 CLR: rf_regsel=dst, rf_funsel=00.
  - 101 and 111 undefined: treated as NOP.
  - 110 JMP: arf_regsel=1000, arf_funsel=01, bus_sel=1.
  - instr_cnt increments for every op, wrapping from all-ones to 0.
  - Next state: HALT if op=111, otherwise FETCH_L.
- HALT: all enables 0. start is ignored; only reset exits.
- Latency: a zero-wait instruction takes 3 cycles (FETCH_L, FETCH_H, EXEC).
- mem_ack outside FETCH_L/FETCH_H is ignored.
- RF/ARF updates take effect at the edge ending the cycle in which their enables are asserted.

Test Plan:
- Reset then start=1 with mem_ack tied high, memory bytes 0x05 then 0x28 (IR=0x2805, LDI dst=01 imm=5) -> R2=5 after cycle 3, PC +2, instr_cnt=1.
- Same flow with mem_ack held low 4 cycles in FETCH_L -> mem_req held, no IR/PC change until ack; total latency 7 cycles.
- Sequence LDI R1,0xFF; INC R1 -> R1=0x00 (wraps); then DEC R1 -> 0xFF; instr_cnt=3.
- JMP 0x40 (IR=0xC040) -> PC=0x40 after EXEC; next FETCH_L presents PC=0x40 on OutB.
- HLT (IR=0xE000) -> halted=1, busy=0, start pulses ignored for 10 cycles; reset -> IDLE, instr_cnt=0.
- Reset asserted in FETCH_H -> IDLE next edge, mem_req=0, no IR/PC update at that edge.
